// File: rtl/rotate_scan_ctrl_pkg.sv
// Shared constants and types for the small-image rotation path.
// Used by the scan sequencer, rotate datapath and frame-buffer arbiter.
package rotate_pkg;

    localparam int IMG_W  = 107;
    localparam int IMG_H  = 80;
    localparam int ADDR_W = 17;
    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [HCNT_W-1:0] h;
        logic [VCNT_W-1:0] v;
    } coord_t;

endpackage

// File: rtl/rotate_scan_ctrl_if.sv
// Control/status bundle between the top-level FSM, arbiter and scan sequencer.
// The sequencer takes the master side; its environment takes the slave side.
interface rotate_scan_if;

    logic                         start_in;
    logic                         abort_in;
    logic                         stall_in;
    logic [rotate_pkg::ADDR_W-1:0] src_addr_out;
    logic [rotate_pkg::HCNT_W-1:0] hcount_out;
    logic [rotate_pkg::VCNT_W-1:0] vcount_out;
    logic                         data_valid_out;
    logic                         busy_out;
    logic                         done_out;

    modport master (
        input  start_in, abort_in, stall_in,
        output src_addr_out, hcount_out, vcount_out,
        output data_valid_out, busy_out, done_out
    );

    modport slave (
        output start_in, abort_in, stall_in,
        input  src_addr_out, hcount_out, vcount_out,
        input  data_valid_out, busy_out, done_out
    );

endinterface

// File: rtl/rotate_scan_ctrl_coord_delay.sv
// Shift register that carries {valid, h, v} alongside the BRAM read latency.
// A synchronous clear drops every in-flight entry on abort or reset.
module coord_delay
    import rotate_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clr_i,
    input  coord_t coord_i,
    output coord_t coord_o
);

    coord_t pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= coord_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign coord_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rotate_scan_ctrl.sv
// Raster-scan sequencer for the rotation path: issues source BRAM addresses,
// aligns coordinates with the read data, drains the datapath, pulses done.
module rotate_scan_ctrl #(
    parameter int IMG_W    = rotate_pkg::IMG_W,
    parameter int IMG_H    = rotate_pkg::IMG_H,
    parameter int SRC_LAT  = 2,
    parameter int PIPE_LAT = 2
) (
    input logic           clk_in,
    input logic           rst_in,
    rotate_scan_if.master bus
);

    import rotate_pkg::state_e;
    import rotate_pkg::coord_t;
    import rotate_pkg::ST_IDLE;
    import rotate_pkg::ST_SCAN;
    import rotate_pkg::ST_DRAIN;
    import rotate_pkg::ST_DONE;

    localparam int AW = rotate_pkg::ADDR_W;
    localparam int HW = rotate_pkg::HCNT_W;
    localparam int VW = rotate_pkg::VCNT_W;
    localparam int CW = 8;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(SRC_LAT + PIPE_LAT);

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, done_q;
    logic          issue, last_h, last_v;
    coord_t        coord_in, coord_out;

    assign last_h = (h_q == HW'(IMG_W - 1));
    assign last_v = (v_q == VW'(IMG_H - 1));
    assign issue  = (state_q == ST_SCAN) && !bus.stall_in;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    state_d = ST_SCAN;
                    h_d     = '0;
                    v_d     = '0;
                    addr_d  = '0;
                end
            end
            ST_SCAN: begin
                if (issue) begin
                    if (last_h && last_v) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        // Raster order keeps the address contiguous.
                        addr_d = addr_q + AW'(1);
                        if (last_h) begin
                            h_d = '0;
                            v_d = v_q + VW'(1);
                        end else begin
                            h_d = h_q + HW'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort_in) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_SCAN) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign coord_in.valid = issue;
    assign coord_in.h     = h_q;
    assign coord_in.v     = v_q;

    coord_delay #(
        .DEPTH (SRC_LAT)
    ) u_coord_delay (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .clr_i   (bus.abort_in),
        .coord_i (coord_in),
        .coord_o (coord_out)
    );

    assign bus.src_addr_out   = addr_q;
    assign bus.hcount_out     = coord_out.h;
    assign bus.vcount_out     = coord_out.v;
    assign bus.data_valid_out = coord_out.valid;
    assign bus.busy_out       = busy_q;
    assign bus.done_out       = done_q;

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Bench for rotate_scan_ctrl: per-frame expectations derived from the
// issue schedule (which cycles issue, which pixel each issue carries).
module tb_rotate_scan_ctrl;

    localparam int W    = 107;
    localparam int H    = 80;
    localparam int SL   = 2;
    localparam int PL   = 2;
    localparam int N    = W * H;
    localparam int LAT  = SL + PL;
    localparam int MAXL = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rotate_scan_if bus ();

    rotate_scan_ctrl #(
        .IMG_W    (W),
        .IMG_H    (H),
        .SRC_LAT  (SL),
        .PIPE_LAT (PL)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit stall_p [MAXL];
    bit start_p [MAXL];
    bit abort_p [MAXL];
    int iss_at  [MAXL];
    bit e_valid [MAXL];
    bit e_busy  [MAXL];
    bit e_done  [MAXL];
    bit e_chka  [MAXL];
    int e_addr  [MAXL];
    int e_idx   [MAXL];
    int n_stall;
    int obs_done;
    int obs_valids;

    task automatic clear_pat(input int L);
        for (int o = 0; o <= L; o++) begin
            stall_p[o] = 1'b0;
            start_p[o] = 1'b0;
            abort_p[o] = 1'b0;
        end
        start_p[0] = 1'b1;
    endtask

    // Offset 0 is the cycle in which start_in is sampled.
    function automatic void build_model(input int L, input int A);
        int cnt = 0;
        int last = -1;
        int endb, scan_end, issued;
        bit complete;
        for (int o = 0; o <= L; o++) begin
            iss_at[o]  = -1;
            e_valid[o] = 1'b0;
            e_busy[o]  = 1'b0;
            e_done[o]  = 1'b0;
            e_chka[o]  = 1'b0;
            e_addr[o]  = 0;
            e_idx[o]   = 0;
        end
        n_stall = 0;
        for (int o = 1; o <= L && cnt < N; o++) begin
            if (A >= 0 && o > A) break;
            if (stall_p[o]) n_stall++;
            else begin
                iss_at[o] = cnt;
                cnt++;
                if (cnt == N) last = o;
            end
        end
        complete = (last >= 0) && (A < 0 || A > last + LAT);
        endb = complete ? last + LAT : ((A >= 0) ? A : L);
        scan_end = (last >= 0) ? last : endb;
        for (int o = 1; o <= L && o <= endb; o++) e_busy[o] = 1'b1;
        if (complete && last + LAT + 1 <= L) e_done[last + LAT + 1] = 1'b1;
        issued = 0;
        for (int o = 1; o <= L; o++) begin
            if (o <= scan_end) begin
                e_chka[o] = 1'b1;
                e_addr[o] = issued;
            end
            if (iss_at[o] >= 0) issued++;
            if (o - SL >= 1 && iss_at[o - SL] >= 0 && (A < 0 || o <= A)) begin
                e_valid[o] = 1'b1;
                e_idx[o]   = iss_at[o - SL];
            end
        end
    endfunction

    // Entered and left just after a rising edge.
    task automatic run_frame(input string name, input int L);
        int exh, exv;
        obs_done   = -1;
        obs_valids = 0;
        for (int o = 0; o <= L; o++) begin
            bus.start_in = start_p[o];
            bus.stall_in = stall_p[o];
            bus.abort_in = abort_p[o];
            @(negedge clk);
            exh = e_idx[o] % W;
            exv = e_idx[o] / W;
            n_tests++;
            if (bus.busy_out !== e_busy[o] || bus.done_out !== e_done[o] ||
                bus.data_valid_out !== e_valid[o] ||
                (e_valid[o] && (bus.hcount_out !== 11'(exh) ||
                                bus.vcount_out !== 10'(exv))) ||
                (e_chka[o] && bus.src_addr_out !== 17'(e_addr[o]))) begin
                n_fail++;
                $display("FAIL %s off=%0d got a=%0d dv=%0b h=%0d v=%0d b=%0b d=%0b want a=%0d(chk %0b) dv=%0b h=%0d v=%0d b=%0b d=%0b",
                         name, o, bus.src_addr_out, bus.data_valid_out,
                         bus.hcount_out, bus.vcount_out, bus.busy_out,
                         bus.done_out, e_addr[o], e_chka[o], e_valid[o],
                         exh, exv, e_busy[o], e_done[o]);
            end
            if (bus.done_out === 1'b1 && obs_done < 0) obs_done = o;
            if (bus.data_valid_out === 1'b1) obs_valids++;
            @(posedge clk);
            #1;
        end
        bus.start_in = 1'b0;
        bus.stall_in = 1'b0;
        bus.abort_in = 1'b0;
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        n_tests++;
        if (bus.src_addr_out !== '0 || bus.hcount_out !== '0 ||
            bus.vcount_out !== '0 || bus.data_valid_out !== 1'b0 ||
            bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got a=%0d h=%0d v=%0d dv=%0b b=%0b d=%0b want all 0",
                     name, bus.src_addr_out, bus.hcount_out, bus.vcount_out,
                     bus.data_valid_out, bus.busy_out, bus.done_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        check_zero("reset_state");
        rst = 1'b1;
        clear_pat(500);
        build_model(500, -1);
        run_frame("pre_reset", 500);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_zero("reset_mid_scan");
        clear_pat(320);
        abort_p[300] = 1'b1;
        build_model(320, 300);
        run_frame("post_reset", 320);
    endtask

    task automatic test_full_frame();
        clear_pat(N + LAT + 5);
        build_model(N + LAT + 5, -1);
        run_frame("full", N + LAT + 5);
        n_tests++;
        if (obs_done !== N + LAT + 1) begin
            n_fail++;
            $display("FAIL full_done_time got %0d want %0d", obs_done, N + LAT + 1);
        end
        n_tests++;
        if (obs_valids !== N) begin
            n_fail++;
            $display("FAIL full_valid_count got %0d want %0d", obs_valids, N);
        end
    endtask

    task automatic test_stall();
        int L = 2 * N + LAT + 5;
        clear_pat(L);
        for (int o = 1; o <= L; o++) stall_p[o] = (o % 2 == 1);
        build_model(L, -1);
        run_frame("stall_alt", L);
        n_tests++;
        if (obs_done !== N + n_stall + LAT + 1) begin
            n_fail++;
            $display("FAIL stall_done_time got %0d want %0d", obs_done, N + n_stall + LAT + 1);
        end
        n_tests++;
        if (obs_valids !== N) begin
            n_fail++;
            $display("FAIL stall_valid_count got %0d want %0d", obs_valids, N);
        end
    endtask

    task automatic test_abort_drain();
        int L = N + 10;
        clear_pat(L);
        abort_p[N + 1] = 1'b1;
        build_model(L, N + 1);
        run_frame("abort_drain", L);
        n_tests++;
        if (obs_done !== -1) begin
            n_fail++;
            $display("FAIL abort_no_done got done at %0d want none", obs_done);
        end
        n_tests++;
        if (obs_valids !== N - 1) begin
            n_fail++;
            $display("FAIL abort_valid_count got %0d want %0d", obs_valids, N - 1);
        end
    endtask

    task automatic test_start_busy();
        int L = N + N / 2 + 100;
        clear_pat(L);
        for (int o = 1; o <= L; o++) stall_p[o] = ($urandom_range(0, 3) == 0);
        build_model(L, -1);
        for (int o = 1; o <= L; o++) begin
            if (iss_at[o] == 200) start_p[o] = 1'b1;
            if (iss_at[o] == N - 1 && o + 2 <= L) start_p[o + 2] = 1'b1;
        end
        run_frame("start_busy", L);
        n_tests++;
        if (obs_done !== N + n_stall + LAT + 1) begin
            n_fail++;
            $display("FAIL busy_done_time got %0d want %0d", obs_done, N + n_stall + LAT + 1);
        end
        n_tests++;
        if (obs_valids !== N) begin
            n_fail++;
            $display("FAIL busy_valid_count got %0d want %0d", obs_valids, N);
        end
    endtask

    task automatic test_back_to_back();
        int L1 = N + LAT + 1;
        int d1;
        clear_pat(L1);
        start_p[L1] = 1'b1;
        build_model(L1, -1);
        run_frame("b2b_first", L1);
        d1 = obs_done;
        clear_pat(L1 + 3);
        build_model(L1 + 3, -1);
        run_frame("b2b_second", L1 + 3);
        n_tests++;
        if (d1 !== N + LAT + 1 || obs_done !== d1) begin
            n_fail++;
            $display("FAIL b2b_done_time got %0d/%0d want %0d/%0d",
                     d1, obs_done, N + LAT + 1, N + LAT + 1);
        end
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.stall_in = 1'b0;
        bus.abort_in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_frame();
        test_stall();
        test_abort_drain();
        test_start_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
